// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  function automatic int rf_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks every entry to zero after reset or on clr_req and
// holds busy high until the last entry has been cleared.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = rf_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx,
  output logic          busy
);

  rf_state_e     r_state;
  logic [AW-1:0] r_idx;

  // A restart mid-sequence clears entry 0 on the restart edge itself, then
  // the index is reloaded so the full DEPTH-edge sweep follows.
  assign clr_idx = clr_req ? '0 : r_idx;
  assign clr_we  = (r_state == RF_CLEAR);
  assign busy    = (r_state == RF_CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RF_CLEAR;
      r_idx   <= '0;
    end else begin
      case (r_state)
        RF_READY: begin
          if (clr_req) begin
            r_state <= RF_CLEAR;
            r_idx   <= '0;
          end
        end
        RF_CLEAR: begin
          if (clr_req) begin
            r_idx <= '0;
          end else if (r_idx == AW'(DEPTH - 1)) begin
            r_state <= RF_READY;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state <= RF_CLEAR;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two prioritised write ports, NREAD bypassed
// combinational read ports, optional hard-wired zero register.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 0,
  localparam int AW = rf_aw(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr_req,
  input  logic [1:0]                   we,
  input  logic [1:0][AW-1:0]           wa,
  input  logic [1:0][WIDTH-1:0]        wd,
  input  logic [NREAD-1:0][AW-1:0]     ra,
  output logic [NREAD-1:0][WIDTH-1:0]  rd,
  output logic                         busy
);

  logic [WIDTH-1:0] r_rf [DEPTH];
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_idx;
  logic [1:0]       w_we;

  regfile_clear_fsm #(
    .DEPTH (DEPTH)
  ) u_clear_fsm (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .clr_we  (w_clr_we),
    .clr_idx (w_clr_idx),
    .busy    (busy)
  );

  always_comb begin
    w_we = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      w_we[p] = we[p] && !busy && !clr_req &&
                !((ZERO_REG != 0) && (wa[p] == '0));
    end
  end

  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_rf[w_clr_idx] <= '0;
    end else begin
      if (w_we[0]) r_rf[wa[0]] <= wd[0];
      if (w_we[1]) r_rf[wa[1]] <= wd[1];
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
    logic [WIDTH-1:0] w_rd;
    always_comb begin
      if (busy)                                    w_rd = '0;
      else if ((ZERO_REG != 0) && (ra[gi] == '0))  w_rd = '0;
      else if (we[1] && (wa[1] == ra[gi]))         w_rd = wd[1];
      else if (we[0] && (wa[0] == ra[gi]))         w_rd = wd[0];
      else                                         w_rd = r_rf[ra[gi]];
    end
    assign rd[gi] = w_rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed checks for regfile_mp: clear sequencing, bypass, write priority,
// zero register, clear restart and asynchronous reset.
module tb_regfile_mp;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr_req;
  logic [1:0]       we;
  logic [1:0][3:0]  wa;
  logic [1:0][31:0] wd;
  logic [1:0][3:0]  ra;
  logic [1:0][31:0] rd;
  logic [1:0][31:0] rdz;
  logic             busy;
  logic             busyz;

  int n_checks = 0;
  int n_errors = 0;
  int n_edges;

  always #5 clk = ~clk;

  regfile_mp #(
    .WIDTH    (32),
    .DEPTH    (16),
    .NREAD    (2),
    .ZERO_REG (0)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .ra      (ra),
    .rd      (rd),
    .busy    (busy)
  );

  regfile_mp #(
    .WIDTH    (32),
    .DEPTH    (16),
    .NREAD    (2),
    .ZERO_REG (1)
  ) u_dutz (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .ra      (ra),
    .rd      (rdz),
    .busy    (busyz)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy falls, bounded by a cycle budget.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (busy && edges < 60) begin
      step();
      edges++;
    end
  endtask

  initial begin
    reset = 1'b1; clr_req = 1'b0; we = '0; wa = '0; wd = '0; ra = '0;
    #3;
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_rd0", rd[0], 32'h0);
    chk("reset_rd1", rd[1], 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 1: reset clear takes exactly 16 edges, array reads zero afterwards
    wait_ready(n_edges);
    chk("reset_clear_edges", 32'(n_edges), 32'd16);
    for (int i = 0; i < 16; i++) begin
      ra[0] = 4'(i);
      ra[1] = 4'(15 - i);
      #1;
      chk("post_reset_rd0", rd[0], 32'h0);
      chk("post_reset_rd1", rd[1], 32'h0);
    end

    // 2: write + same-cycle bypass, then array read
    we = 2'b01; wa[0] = 4'd5; wd[0] = 32'hDEADBEEF; ra[0] = 4'd5; ra[1] = 4'd6;
    #1;
    chk("bypass_r5", rd[0], 32'hDEADBEEF);
    chk("no_bypass_r6", rd[1], 32'h0);
    step();
    we = 2'b00;
    #1;
    chk("array_r5", rd[0], 32'hDEADBEEF);

    // 3: same-address conflict, port 1 wins
    we = 2'b11; wa[0] = 4'd3; wa[1] = 4'd3; wd[0] = 32'h11; wd[1] = 32'h22; ra[0] = 4'd3;
    #1;
    chk("conflict_bypass", rd[0], 32'h22);
    step();
    we = 2'b00;
    #1;
    chk("conflict_array", rd[0], 32'h22);
    we = 2'b11; wa[0] = 4'd3; wa[1] = 4'd4; wd[0] = 32'h33; wd[1] = 32'h44;
    step();
    we = 2'b00; ra[0] = 4'd3; ra[1] = 4'd4;
    #1;
    chk("dual_r3", rd[0], 32'h33);
    chk("dual_r4", rd[1], 32'h44);

    // 4: zero register discards writes on the ZERO_REG instance only
    we = 2'b01; wa[0] = 4'd0; wd[0] = 32'h0000FFFF; ra[0] = 4'd0; ra[1] = 4'd0;
    #1;
    chk("zreg_bypass", rdz[0], 32'h0);
    chk("nozreg_bypass", rd[0], 32'h0000FFFF);
    step();
    we = 2'b00;
    #1;
    chk("zreg_array", rdz[0], 32'h0);
    chk("nozreg_array", rd[0], 32'h0000FFFF);

    // 5: fill, request clear, restart on clear edge 7
    for (int i = 0; i < 16; i += 2) begin
      we = 2'b11;
      wa[0] = 4'(i);     wd[0] = 32'h100 + 32'(i);
      wa[1] = 4'(i + 1); wd[1] = 32'h100 + 32'(i + 1);
      step();
    end
    we = 2'b00; ra[0] = 4'd9; ra[1] = 4'd14;
    #1;
    chk("fill_r9", rd[0], 32'h109);
    chk("fill_r14", rd[1], 32'h10E);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("clr_req_busy", 32'(busy), 32'd1);
    we = 2'b11; wa[0] = 4'd2; wd[0] = 32'hAAAA; wa[1] = 4'd15; wd[1] = 32'hBBBB;
    ra[0] = 4'd2;
    #1;
    chk("busy_read_zero", rd[0], 32'h0);
    n_edges = 0;
    while (busy && n_edges < 60) begin
      clr_req = (n_edges == 6);
      step();
      n_edges++;
    end
    clr_req = 1'b0;
    we = 2'b00;
    chk("restart_busy_edges", 32'(n_edges), 32'd23);
    for (int i = 0; i < 16; i++) begin
      ra[0] = 4'(i);
      #1;
      chk("post_clear_rd", rd[0], 32'h0);
    end

    // 6: asynchronous reset between edges while writing
    we = 2'b11; wa[0] = 4'd7; wd[0] = 32'h77; wa[1] = 4'd8; wd[1] = 32'h88;
    ra[0] = 4'd7; ra[1] = 4'd8;
    step();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 32'd1);
    chk("async_rd0", rd[0], 32'h0);
    chk("async_rd1", rd[1], 32'h0);
    we = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n_edges);
    chk("async_clear_edges", 32'(n_edges), 32'd16);
    #1;
    chk("async_post_rd0", rd[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, successor to the 16×32 three-port regfile. It provides configurable width, depth and read-port count, two write ports with fixed priority, and same-cycle write-to-read bypass. It also has an optional hard-wired zero register and a hardware clear sequencer that zeroes every entry after reset or on request. It sits in the decode/writeback boundary of the CPU datapath; the core stalls issue while `busy` is high.

## Interface
Parameters:
- `WIDTH` = 32: bits per register.
- `DEPTH` = 16: number of registers; must be a power of two, at least 2.
- `NREAD` = 2: number of combinational read ports, 1..4.
- `ZERO_REG` = 0: if 1, register 0 always reads 0 and writes to it are discarded.

Ports (AW = $clog2(DEPTH)):
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `clr_req` input 1: request a full clear sequence; sampled on the rising edge.
- `we` input [1:0]: write enable per write port.
- `wa` input [1:0][AW-1:0]: write address per write port.
- `wd` input [1:0][WIDTH-1:0]: write data per write port.
- `ra` input [NREAD-1:0][AW-1:0]: read addresses.
- `rd` output [NREAD-1:0][WIDTH-1:0]: read data, combinational.
- `busy` output 1: clear sequence in progress; writes are ignored.

## Operation
State machine, two states:
- **CLEAR**: entered asynchronously by `reset`, or from READY on an edge where `clr_req`=1.
  - Each rising edge writes 0 to entry `clr_idx`, then increments `clr_idx`.
  - On the edge that clears entry DEPTH-1, the state moves to READY.
- **READY**: normal operation; `busy`=0.

Writes (READY only):
- Port p commits `wd[p]` to `rf[wa[p]]` on the rising edge when `we[p]`=1.
- Both ports enabled with equal addresses: port 1 wins; port 0 data is dropped.
- `ZERO_REG`=1 and `wa[p]`=0: that write is discarded.
- All writes presented on the `clr_req` edge, and throughout CLEAR, are dropped.

Reads, per port i, in priority order:
- `busy`=1 → 0.
- `ZERO_REG`=1 and `ra[i]`=0 → 0.
- `we[1]` and `wa[1]`==`ra[i]` → `wd[1]` (bypass).
- `we[0]` and `wa[0]`==`ra[i]` → `wd[0]` (bypass).
- Otherwise → `rf[ra[i]]`.

Boundary conditions:
- `clr_req` during CLEAR: `clr_idx` restarts at 0 on that edge, and the entry cleared on that edge is entry 0.
- `reset` mid-CLEAR or mid-write: `clr_idx`=0 immediately and state=CLEAR. The array contents are undefined until the sequence completes.
- `clr_idx` is AW bits and wraps only at the terminal transition; it never exceeds DEPTH-1.
- Bypass uses the current-cycle write inputs, not registered values. A read therefore never observes stale data across a write edge.

## Timing
- Reset values: state=CLEAR, `clr_idx`=0, `busy`=1, all `rd`=0.
- Clear latency: exactly DEPTH rising edges after `reset` deasserts.
  - Edge k (1-based) clears entry k-1.
  - `busy` falls immediately after edge DEPTH.
- `clr_req` in READY: `busy` rises after that edge. The next DEPTH edges clear entries 0..DEPTH-1, so `busy` is high for DEPTH cycles.
- Write-to-read latency: 0 cycles via bypass; from the array, visible in the cycle after the write edge.
- Read path is purely combinational from `ra`, `we`, `wa`, `wd` and `busy`.

## Structure
- Package `regfile_pkg` holds:
  - the state enum `rf_state_e` {RF_CLEAR, RF_READY};
  - the function `rf_aw(depth)` returning $clog2.
- Sub-module `regfile_clear_fsm` owns the state, `clr_idx`, `clr_req` handling and the `busy` generation. It outputs `clr_we`/`clr_idx` to the array.
- The top level holds the storage array, write arbitration and a generate loop of NREAD bypass read muxes.

## Test plan
1. **Reset clear.** Assert `reset` with `DEPTH`=16, then release. Required: `busy`=1 for exactly 16 edges; afterwards `ra`=0..15 all read 0.
2. **Write and bypass.** Write 0xDEADBEEF to r5 via port 0. Required: in the same cycle `ra[0]`=5 gives 0xDEADBEEF; the next cycle without `we` still reads 0xDEADBEEF.
3. **Dual-write conflict.** Port 0 writes r3=0x11 and port 1 writes r3=0x22 on the same edge. Required: the bypass read shows 0x22 and the later array read is 0x22. Also write r3 and r4 simultaneously via different ports; both must commit.
4. **Zero register.** With `ZERO_REG`=1, write r0=0xFFFF. Required: the bypass and later reads of r0 return 0.
5. **Mid-clear restart.** Fill r0..r15 with nonzero values, pulse `clr_req`, then pulse it again on clear edge 7. Required: `busy` stays high for 7+16 edges total; all entries read 0; writes presented during `busy` have no effect.
6. **Async reset during writes.** Assert `reset` between edges while `we`=2'b11. Required: `busy`=1 and `rd`=0 immediately, with no clock edge needed.
